otter_mdu: RTL and testbench

// - Iterative RV32M multiply/divide unit in the execute stage. Operands come from
//   the register-file read ports (rs1/rs2). The result returns through the

---
 rtl/otter_mdu_if.sv | 39 +++
 rtl/otter_mdu.sv | 221 ++++++++++++++++++++++
 tb/tb_otter_mdu.sv | 174 +++++++++++++++++
 3 files changed

// File: rtl/otter_mdu_if.sv
// -----------------------------------------------------------------------------
// otter_mdu_if
// Request/response bundle between the execute stage and the iterative RV32M
// multiply/divide unit.
//   start   : request, sampled only while the unit is idle
//   funct3  : RV32M operation select
//   rs1/rs2 : operands (only valid in the start cycle)
//   rd_in   : destination register, captured with start
//   busy    : unit is not idle (pipeline stall)
//   done    : one-cycle result-valid pulse
//   result  : registered result, held until the next result is produced
//   w_adr   : destination register captured with the request
//   rf_we   : register-file write enable, identical to done
// Modports: master = requester (execute stage), slave = the MDU.
// -----------------------------------------------------------------------------
interface otter_mdu_if #(
    parameter int XLEN = 32
);
    logic            start;
    logic [2:0]      funct3;
    logic [XLEN-1:0] rs1;
    logic [XLEN-1:0] rs2;
    logic [4:0]      rd_in;
    logic            busy;
    logic            done;
    logic [XLEN-1:0] result;
    logic [4:0]      w_adr;
    logic            rf_we;

    modport master (
        output start, funct3, rs1, rs2, rd_in,
        input  busy, done, result, w_adr, rf_we
    );

    modport slave (
        input  start, funct3, rs1, rs2, rd_in,
        output busy, done, result, w_adr, rf_we
    );
endinterface

// File: rtl/otter_mdu.sv
// -----------------------------------------------------------------------------
// otter_mdu
// Iterative RV32M multiply/divide unit. A shift-add multiplier and a restoring
// divider share one FSM, one 2*XLEN accumulator and one step counter. Signed
// operands are reduced to magnitudes at capture and the final value is negated
// on exit. Divide-by-zero and signed overflow are resolved in IDLE.
//
// Ports:
//   clk : clock, all state updates on posedge
//   rst : asynchronous, active-high reset
//   mdu : otter_mdu_if.slave (start/funct3/rs1/rs2/rd_in in;
//                             busy/done/result/w_adr/rf_we out)
//
// Configuration macro: MDU_FAST_MUL_EN
//   defined   : multiplies use one combinational 2*XLEN product and go from
//               IDLE straight to DONE; the MUL state datapath is not built.
//   undefined : multiplies iterate one multiplier bit per cycle (default).
// -----------------------------------------------------------------------------
module otter_mdu #(
    parameter int XLEN = 32
) (
    input  logic      clk,
    input  logic      rst,
    otter_mdu_if.slave mdu
);
    localparam int CW = $clog2(XLEN) + 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DIV  = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t            state_reg, state_next;
    logic [CW-1:0]     count_reg, count_next;
    logic [2*XLEN-1:0] acc_reg, acc_next;      // {hi, lo} product or {rem, quot}
    logic [XLEN-1:0]   opnd_reg, opnd_next;    // multiplicand or divisor magnitude
    logic [2:0]        f3_reg, f3_next;
    logic [4:0]        rd_reg, rd_next;
    logic              neg_q_reg, neg_q_next;  // negate product / quotient
    logic              neg_r_reg, neg_r_next;  // negate remainder (dividend sign)
    logic [XLEN-1:0]   result_reg, result_next;
    logic [4:0]        w_adr_reg, w_adr_next;

    // ---------------- operand capture decode ----------------
    logic            is_mul;
    logic            signed_a, signed_b;
    logic            sign_a, sign_b;
    logic [XLEN-1:0] a_mag, b_mag;
    logic            div_by_zero, div_ovf;

    always_comb begin
        is_mul   = ~mdu.funct3[2];
        // MULH (01) and MULHSU (10) treat rs1 as signed; DIV/REM have funct3[0]=0
        signed_a = is_mul ? (mdu.funct3[1:0] == 2'b01 || mdu.funct3[1:0] == 2'b10)
                          : ~mdu.funct3[0];
        signed_b = is_mul ? (mdu.funct3[1:0] == 2'b01) : ~mdu.funct3[0];
        sign_a   = signed_a & mdu.rs1[XLEN-1];
        sign_b   = signed_b & mdu.rs2[XLEN-1];
        a_mag    = sign_a ? (~mdu.rs1 + 1'b1) : mdu.rs1;
        b_mag    = sign_b ? (~mdu.rs2 + 1'b1) : mdu.rs2;
        div_by_zero = (mdu.rs2 == '0);
        div_ovf     = ~mdu.funct3[0]
                    && (mdu.rs1 == {1'b1, {(XLEN-1){1'b0}}})
                    && (mdu.rs2 == {XLEN{1'b1}});
    end

    function automatic logic [XLEN-1:0] sel_mul(input logic [2:0] f3,
                                                input logic [2*XLEN-1:0] p);
        // MUL returns the low half, every other multiply the high half
        return (f3[1:0] == 2'b00) ? p[XLEN-1:0] : p[2*XLEN-1:XLEN];
    endfunction

    // ---------------- divide step ----------------
    logic [XLEN:0]     div_shift, div_diff;
    logic [2*XLEN-1:0] div_step;
    logic [XLEN-1:0]   div_q, div_r;
    logic [XLEN-1:0]   div_final;

    always_comb begin
        div_shift = {acc_reg[2*XLEN-1:XLEN], acc_reg[XLEN-1]};
        div_diff  = div_shift - {1'b0, opnd_reg};
        if (!div_diff[XLEN])
            div_step = {div_diff[XLEN-1:0], acc_reg[XLEN-2:0], 1'b1};
        else
            div_step = {div_shift[XLEN-1:0], acc_reg[XLEN-2:0], 1'b0};
        div_q = div_step[XLEN-1:0];
        div_r = div_step[2*XLEN-1:XLEN];
        if (f3_reg[1])
            div_final = neg_r_reg ? (~div_r + 1'b1) : div_r;
        else
            div_final = neg_q_reg ? (~div_q + 1'b1) : div_q;
    end

`ifdef MDU_FAST_MUL_EN
    // ---------------- single-cycle multiply ----------------
    logic [2*XLEN-1:0] fast_prod, fast_signed;
    always_comb begin
        fast_prod   = {{XLEN{1'b0}}, a_mag} * {{XLEN{1'b0}}, b_mag};
        fast_signed = (sign_a ^ sign_b) ? (~fast_prod + 1'b1) : fast_prod;
    end
`else
    // ---------------- shift-add multiply step ----------------
    // Low half holds the unconsumed multiplier bits; each step adds the
    // multiplicand into the high half on a 1 bit and shifts right.
    logic [XLEN:0]     mul_sum;
    logic [2*XLEN-1:0] mul_step, mul_signed;
    always_comb begin
        mul_sum  = {1'b0, acc_reg[2*XLEN-1:XLEN]} + {1'b0, opnd_reg};
        if (acc_reg[0])
            mul_step = {mul_sum, acc_reg[XLEN-1:1]};
        else
            mul_step = {1'b0, acc_reg[2*XLEN-1:1]};
        mul_signed = neg_q_reg ? (~mul_step + 1'b1) : mul_step;
    end
`endif

    // ---------------- next-state / datapath ----------------
    always_comb begin
        state_next  = state_reg;
        count_next  = count_reg;
        acc_next    = acc_reg;
        opnd_next   = opnd_reg;
        f3_next     = f3_reg;
        rd_next     = rd_reg;
        neg_q_next  = neg_q_reg;
        neg_r_next  = neg_r_reg;
        result_next = result_reg;
        w_adr_next  = w_adr_reg;

        case (state_reg)
            IDLE: begin
                if (mdu.start) begin
                    f3_next    = mdu.funct3;
                    rd_next    = mdu.rd_in;
                    count_next = '0;
                    neg_q_next = sign_a ^ sign_b;
                    neg_r_next = sign_a;
                    if (is_mul) begin
`ifdef MDU_FAST_MUL_EN
                        state_next  = DONE;
                        result_next = sel_mul(mdu.funct3, fast_signed);
                        w_adr_next  = mdu.rd_in;
`else
                        state_next = MUL;
                        acc_next   = {{XLEN{1'b0}}, b_mag};
                        opnd_next  = a_mag;
`endif
                    end else if (div_by_zero) begin
                        state_next  = DONE;
                        result_next = mdu.funct3[1] ? mdu.rs1 : {XLEN{1'b1}};
                        w_adr_next  = mdu.rd_in;
                    end else if (div_ovf) begin
                        state_next  = DONE;
                        result_next = mdu.funct3[1] ? '0 : {1'b1, {(XLEN-1){1'b0}}};
                        w_adr_next  = mdu.rd_in;
                    end else begin
                        state_next = DIV;
                        acc_next   = {{XLEN{1'b0}}, a_mag};
                        opnd_next  = b_mag;
                    end
                end
            end
`ifndef MDU_FAST_MUL_EN
            MUL: begin
                acc_next   = mul_step;
                count_next = count_reg + 1'b1;
                if (count_reg == CW'(XLEN-1)) begin
                    state_next  = DONE;
                    result_next = sel_mul(f3_reg, mul_signed);
                    w_adr_next  = rd_reg;
                end
            end
`endif
            DIV: begin
                acc_next   = div_step;
                count_next = count_reg + 1'b1;
                if (count_reg == CW'(XLEN-1)) begin
                    state_next  = DONE;
                    result_next = div_final;
                    w_adr_next  = rd_reg;
                end
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg  <= IDLE;
            count_reg  <= '0;
            acc_reg    <= '0;
            opnd_reg   <= '0;
            f3_reg     <= '0;
            rd_reg     <= '0;
            neg_q_reg  <= 1'b0;
            neg_r_reg  <= 1'b0;
            result_reg <= '0;
            w_adr_reg  <= '0;
        end else begin
            state_reg  <= state_next;
            count_reg  <= count_next;
            acc_reg    <= acc_next;
            opnd_reg   <= opnd_next;
            f3_reg     <= f3_next;
            rd_reg     <= rd_next;
            neg_q_reg  <= neg_q_next;
            neg_r_reg  <= neg_r_next;
            result_reg <= result_next;
            w_adr_reg  <= w_adr_next;
        end
    end

    assign mdu.busy   = (state_reg != IDLE);
    assign mdu.done   = (state_reg == DONE);
    assign mdu.rf_we  = (state_reg == DONE);
    assign mdu.result = result_reg;
    assign mdu.w_adr  = w_adr_reg;
endmodule

// File: tb/tb_otter_mdu.sv
// -----------------------------------------------------------------------------
// tb_otter_mdu
// Directed testbench for otter_mdu: reset values, every RV32M flavour, the
// divide special cases, latency, start-while-busy filtering, back-to-back
// acceptance and asynchronous reset in the middle of a divide.
// -----------------------------------------------------------------------------
module tb_otter_mdu;
    localparam int XLEN = 32;
`ifdef MDU_FAST_MUL_EN
    localparam int MUL_LAT = 1;
`else
    localparam int MUL_LAT = 33;
`endif
    localparam int DIV_LAT = 33;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total_cnt = 0;
    int   pass_cnt  = 0;

    otter_mdu_if #(.XLEN(XLEN)) mdu_bus ();

    otter_mdu #(.XLEN(XLEN)) dut (
        .clk (clk),
        .rst (rst),
        .mdu (mdu_bus.slave)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_cnt++;
        assert (obs === exp) begin
            pass_cnt++;
        end else begin
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Wait (bounded) for done; latency counted as cycles from the start edge.
    task automatic wait_done(input string tag, input int exp_lat);
        int n = 1;
        while (mdu_bus.done !== 1'b1 && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        check({tag, " done"}, {31'd0, mdu_bus.done}, 32'd1);
        check({tag, " latency"}, n, exp_lat);
    endtask

    // Issue one op (called #1 after a posedge, unit idle), check the result.
    task automatic do_op(input string tag, input logic [2:0] f3,
                         input logic [31:0] a, input logic [31:0] b, input logic [4:0] rd,
                         input logic [31:0] exp_res, input int exp_lat);
        mdu_bus.start  = 1'b1;
        mdu_bus.funct3 = f3;
        mdu_bus.rs1    = a;
        mdu_bus.rs2    = b;
        mdu_bus.rd_in  = rd;
        @(posedge clk); #1;
        mdu_bus.start = 1'b0;
        mdu_bus.rs1   = $urandom;       // operands only valid in the start cycle
        mdu_bus.rs2   = $urandom;
        mdu_bus.rd_in = 5'($urandom);
        wait_done(tag, exp_lat);
        check({tag, " result"}, mdu_bus.result, exp_res);
        check({tag, " w_adr"}, {27'd0, mdu_bus.w_adr}, {27'd0, rd});
        check({tag, " rf_we"}, {31'd0, mdu_bus.rf_we}, 32'd1);
        $display("op %s f3=%0d rs1=%h rs2=%h -> result=%h w_adr=%0d", tag, f3, a, b,
                 mdu_bus.result, mdu_bus.w_adr);
        @(posedge clk); #1;
        check({tag, " done pulse"}, {31'd0, mdu_bus.done}, 32'd0);
    endtask

    initial begin
        int pulses;
        mdu_bus.start  = 1'b0;
        mdu_bus.funct3 = 3'd0;
        mdu_bus.rs1    = '0;
        mdu_bus.rs2    = '0;
        mdu_bus.rd_in  = '0;

        // reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst busy",   {31'd0, mdu_bus.busy},  32'd0);
        check("rst done",   {31'd0, mdu_bus.done},  32'd0);
        check("rst rf_we",  {31'd0, mdu_bus.rf_we}, 32'd0);
        check("rst result", mdu_bus.result, 32'd0);
        check("rst w_adr",  {27'd0, mdu_bus.w_adr}, 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        // multiplies
        do_op("MUL",    3'b000, 32'd7,        32'hFFFFFFFD, 5'd5,  32'hFFFFFFEB, MUL_LAT);
        do_op("MULH",   3'b001, 32'h80000000, 32'h80000000, 5'd6,  32'h40000000, MUL_LAT);
        do_op("MULHU",  3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd7,  32'hFFFFFFFE, MUL_LAT);
        do_op("MULHSU", 3'b010, 32'hFFFFFFFF, 32'd2,        5'd8,  32'hFFFFFFFF, MUL_LAT);
        do_op("MUL2",   3'b000, 32'd1234,     32'd5678,     5'd9,  32'd7006652,  MUL_LAT);

        // divides
        do_op("DIV",    3'b100, 32'hFFFFFFF9, 32'd2,        5'd10, 32'hFFFFFFFD, DIV_LAT);
        do_op("REM",    3'b110, 32'hFFFFFFF9, 32'd2,        5'd11, 32'hFFFFFFFF, DIV_LAT);
        do_op("DIVU",   3'b101, 32'd100,      32'd7,        5'd12, 32'd14,       DIV_LAT);
        do_op("REMU",   3'b111, 32'd100,      32'd7,        5'd13, 32'd2,        DIV_LAT);

        // divide special cases
        do_op("DIVU/0", 3'b101, 32'd5,        32'd0,        5'd14, 32'hFFFFFFFF, 1);
        do_op("REM/0",  3'b110, 32'd5,        32'd0,        5'd15, 32'd5,        1);
        do_op("DIVOVF", 3'b100, 32'h80000000, 32'hFFFFFFFF, 5'd16, 32'h80000000, 1);
        do_op("REMOVF", 3'b110, 32'h80000000, 32'hFFFFFFFF, 5'd0,  32'd0,        1);

        // start held every cycle during a DIV: one op, one done pulse,
        // then a start in the IDLE cycle after done is accepted
        mdu_bus.start  = 1'b1;
        mdu_bus.funct3 = 3'b101;
        mdu_bus.rs1    = 32'd100;
        mdu_bus.rs2    = 32'd7;
        mdu_bus.rd_in  = 5'd1;
        @(posedge clk); #1;
        mdu_bus.rs1   = 32'd1000;
        mdu_bus.rs2   = 32'd3;
        mdu_bus.rd_in = 5'd2;
        pulses = 0;
        for (int k = 1; k <= 33; k++) begin
            if (mdu_bus.done === 1'b1) begin
                pulses++;
                check("hold result", mdu_bus.result, 32'd14);
                check("hold w_adr", {27'd0, mdu_bus.w_adr}, 32'd1);
                mdu_bus.funct3 = 3'b111;
                mdu_bus.rs1    = 32'd100;
                mdu_bus.rs2    = 32'd7;
                mdu_bus.rd_in  = 5'd3;
            end
            @(posedge clk); #1;
        end
        check("hold pulses", pulses, 32'd1);
        check("hold idle", {31'd0, mdu_bus.busy}, 32'd0);
        @(posedge clk); #1;
        mdu_bus.start = 1'b0;
        check("b2b accepted", {31'd0, mdu_bus.busy}, 32'd1);
        wait_done("b2b", DIV_LAT);
        check("b2b result", mdu_bus.result, 32'd2);
        check("b2b w_adr", {27'd0, mdu_bus.w_adr}, 32'd3);
        $display("op b2b REMU 100/7 -> result=%h w_adr=%0d", mdu_bus.result, mdu_bus.w_adr);
        @(posedge clk); #1;

        // asynchronous reset at count=10 of a DIV
        mdu_bus.start  = 1'b1;
        mdu_bus.funct3 = 3'b100;
        mdu_bus.rs1    = 32'd1000;
        mdu_bus.rs2    = 32'd3;
        mdu_bus.rd_in  = 5'd20;
        @(posedge clk); #1;
        mdu_bus.start = 1'b0;
        repeat (10) @(posedge clk);
        #2;
        check("pre-rst busy", {31'd0, mdu_bus.busy}, 32'd1);
        rst = 1'b1;
        #1;
        check("midrst busy",   {31'd0, mdu_bus.busy}, 32'd0);
        check("midrst done",   {31'd0, mdu_bus.done}, 32'd0);
        check("midrst result", mdu_bus.result, 32'd0);
        check("midrst w_adr",  {27'd0, mdu_bus.w_adr}, 32'd0);
        $display("op midrst DIV aborted by reset");
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        do_op("postrst", 3'b100, 32'd1000, 32'd3, 5'd21, 32'd333, DIV_LAT);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
